// File: rtl/lms_ctr_led_pkg.sv
// rtl/lms_ctr_led_pkg.sv - register map, LED mode encoding and reset defaults for the LED PIO
package lms_ctr_led_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_SET      = 3'd2;
  localparam logic [2:0] ADDR_CLEAR    = 3'd3;
  localparam logic [2:0] ADDR_BLINK    = 3'd4;
  localparam logic [2:0] ADDR_DUTY     = 3'd5;
  localparam logic [2:0] ADDR_TICK_DIV = 3'd6;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_INV    = 2'b11
  } led_mode_e;

  localparam int          DEF_NUM_LEDS = 8;
  localparam int          DEF_PWM_BITS = 4;
  localparam logic [15:0] DEF_TICK_DIV = 16'd49999;
  localparam logic [15:0] DEF_BLINK    = 16'd250;

endpackage

// File: rtl/lms_ctr_led_pio_if.sv
// rtl/lms_ctr_led_pio_if.sv - Avalon-MM slave bus bundle for the LED PIO
interface lms_ctr_led_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lms_ctr_led_tickgen.sv
// rtl/lms_ctr_led_tickgen.sv - shared prescaler, blink phase generator and PWM comparator
module lms_ctr_led_tickgen #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [15:0]         tick_div,
  input  logic [15:0]         blink,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                tick_clr,
  input  logic                blink_clr,
  output logic                tick,
  output logic                phase,
  output logic                pwm_on
);

  logic [15:0]         tick_cnt;
  logic [15:0]         blink_cnt;
  logic [15:0]         blink_lim;
  logic [PWM_BITS-1:0] pwm_cnt;

  assign tick      = (tick_cnt == tick_div);
  // A half-period of zero is treated as one tick.
  assign blink_lim = (blink == 16'd0) ? 16'd0 : blink - 16'd1;
  assign pwm_on    = (pwm_cnt < duty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      pwm_cnt   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;

      if (tick_clr || tick) tick_cnt <= '0;
      else                  tick_cnt <= tick_cnt + 16'd1;

      if (blink_clr) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (tick) begin
        if (blink_cnt >= blink_lim) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/lms_ctr_led_pio.sv
// rtl/lms_ctr_led_pio.sv - Avalon-MM LED output port with per-LED static/blink/PWM/invert modes
module lms_ctr_led_pio
  import lms_ctr_led_pkg::*;
#(
  parameter int                   NUM_LEDS     = DEF_NUM_LEDS,
  parameter logic [15:0]          TICK_DIV_RST = DEF_TICK_DIV,
  parameter logic [15:0]          BLINK_RST    = DEF_BLINK,
  parameter int                   PWM_BITS     = DEF_PWM_BITS,
  parameter logic [NUM_LEDS-1:0]  DATA_RST     = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  lms_ctr_led_pio_if.slave     bus,
  output logic [NUM_LEDS-1:0]  out_port
);

  logic [NUM_LEDS-1:0]   data;
  logic [2*NUM_LEDS-1:0] mode;
  logic [15:0]           blink;
  logic [PWM_BITS-1:0]   duty;
  logic [15:0]           tick_div;
  logic                  wr_en;
  logic                  phase;
  logic                  pwm_on;
  logic                  unused_tick;
  logic [NUM_LEDS-1:0]   led_next;

  assign wr_en = bus.chipselect && !bus.write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data     <= DATA_RST;
      mode     <= '0;
      blink    <= BLINK_RST;
      duty     <= '0;
      tick_div <= TICK_DIV_RST;
    end else if (wr_en) begin
      case (bus.address)
        ADDR_DATA:     data     <= bus.writedata[NUM_LEDS-1:0];
        ADDR_MODE:     mode     <= bus.writedata[2*NUM_LEDS-1:0];
        ADDR_SET:      data     <= data | bus.writedata[NUM_LEDS-1:0];
        ADDR_CLEAR:    data     <= data & ~bus.writedata[NUM_LEDS-1:0];
        ADDR_BLINK:    blink    <= bus.writedata[15:0];
        ADDR_DUTY:     duty     <= bus.writedata[PWM_BITS-1:0];
        ADDR_TICK_DIV: tick_div <= bus.writedata[15:0];
        default:       ;
      endcase
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:     bus.readdata[NUM_LEDS-1:0]   = data;
      ADDR_MODE:     bus.readdata[2*NUM_LEDS-1:0] = mode;
      ADDR_BLINK:    bus.readdata[15:0]           = blink;
      ADDR_DUTY:     bus.readdata[PWM_BITS-1:0]   = duty;
      ADDR_TICK_DIV: bus.readdata[15:0]           = tick_div;
      default:       ;
    endcase
  end

  lms_ctr_led_tickgen #(.PWM_BITS(PWM_BITS)) u_tickgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick_div  (tick_div),
    .blink     (blink),
    .duty      (duty),
    .tick_clr  (wr_en && bus.address == ADDR_TICK_DIV),
    .blink_clr (wr_en && bus.address == ADDR_BLINK),
    .tick      (unused_tick),
    .phase     (phase),
    .pwm_on    (pwm_on)
  );

  always_comb begin
    led_next = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (led_mode_e'(mode[2*i +: 2]))
        MODE_STATIC: led_next[i] = data[i];
        MODE_BLINK:  led_next[i] = data[i] & phase;
        MODE_PWM:    led_next[i] = data[i] & pwm_on;
        MODE_INV:    led_next[i] = ~data[i];
        default:     led_next[i] = data[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= '0;
    else          out_port <= led_next;
  end

endmodule

// File: tb/tb_lms_ctr_led_pio.sv
// tb/tb_lms_ctr_led_pio.sv - scoreboard bench for the LED PIO register file, generators and reset
module tb_lms_ctr_led_pio;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] out_port;

  always #5 clk = ~clk;

  lms_ctr_led_pio_if bus ();

  lms_ctr_led_pio #(
    .NUM_LEDS     (8),
    .TICK_DIV_RST (16'd49999),
    .BLINK_RST    (16'd250),
    .PWM_BITS     (4),
    .DATA_RST     (8'h00)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic expect_pop(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_eq(t, obs, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = wd;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd_check(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    expect_push(tag, exp);
    #1;
    expect_pop(bus.readdata);
    bus.chipselect = 1'b0;
  endtask

  task automatic out_check(input logic [7:0] exp, input string tag);
    expect_push(tag, {24'd0, exp});
    expect_pop({24'd0, out_port});
  endtask

  task automatic measure_toggle(input int period, input int n, input string tag);
    logic prev;
    int   cyc;
    int   seen;
    prev = out_port[0];
    cyc  = 0;
    seen = 0;
    for (int k = 0; k < 300 && seen <= n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_port[0] !== prev) begin
        prev = out_port[0];
        if (seen > 0) begin
          expect_push(tag, period);
          expect_pop(cyc);
        end
        seen++;
        cyc = 0;
      end
    end
    if (seen <= n) check_eq({tag, "_timeout"}, seen, n + 1);
  endtask

  task automatic pwm_count(input int exp_hi, input string tag);
    int hi;
    hi = 0;
    expect_push(tag, exp_hi);
    repeat (16) begin
      @(posedge clk);
      #1;
      hi += int'(out_port[1]);
    end
    expect_pop(hi);
  endtask

  initial begin
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    #1;
    out_check(8'h00, "rst_out");
    step(3);
    rd_check(3'd0, 32'h0000_0000, "rst_data");
    rd_check(3'd1, 32'h0000_0000, "rst_mode");
    rd_check(3'd4, 32'd250,       "rst_blink");
    rd_check(3'd5, 32'h0000_0000, "rst_duty");
    rd_check(3'd6, 32'd49999,     "rst_tick_div");
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    out_check(8'h00, "post_rst_out");

    wr(3'd0, 32'h0000_00A5);
    out_check(8'h00, "data_edge1");
    step(1);
    out_check(8'hA5, "data_edge2");
    rd_check(3'd0, 32'h0000_00A5, "rd_data_a5");

    wr(3'd0, 32'h0000_00F0);
    wr(3'd2, 32'h0000_000F);
    wr(3'd3, 32'h0000_0030);
    rd_check(3'd0, 32'h0000_00CF, "set_clear");
    rd_check(3'd2, 32'h0000_0000, "rd_set_zero");
    rd_check(3'd3, 32'h0000_0000, "rd_clear_zero");
    step(1);
    out_check(8'hCF, "out_cf");
    wr(3'd0, 32'hFFFF_FFFF);
    rd_check(3'd0, 32'h0000_00FF, "data_unused_bits");
    wr(3'd1, 32'hFFFF_FFFF);
    rd_check(3'd1, 32'h0000_FFFF, "mode_unused_bits");

    wr(3'd6, 32'd1);
    wr(3'd4, 32'd3);
    wr(3'd1, 32'h0000_0001);
    wr(3'd0, 32'h0000_0001);
    rd_check(3'd6, 32'd1, "rd_tick_div");
    rd_check(3'd4, 32'd3, "rd_blink");
    measure_toggle(6, 3, "blink_period6");
    expect_push("blink_others_static", 32'd0);
    expect_pop({24'd0, out_port & 8'hFE});
    wr(3'd4, 32'd0);
    measure_toggle(2, 3, "blink_zero_as_one");

    wr(3'd1, 32'h0000_0008);
    wr(3'd0, 32'h0000_0002);
    wr(3'd5, 32'd4);
    step(2);
    pwm_count(4, "pwm_duty4");
    wr(3'd5, 32'd0);
    step(2);
    pwm_count(0, "pwm_duty0");
    wr(3'd5, 32'd15);
    step(2);
    pwm_count(15, "pwm_duty15");
    rd_check(3'd5, 32'd15, "rd_duty");

    wr(3'd1, 32'h0000_FFFF);
    wr(3'd0, 32'h0000_0000);
    step(1);
    out_check(8'hFF, "inverted_all");
    wr(3'd7, 32'hDEAD_BEEF);
    rd_check(3'd7, 32'h0000_0000, "rd_reserved");
    rd_check(3'd0, 32'h0000_0000, "resv_data_kept");
    rd_check(3'd1, 32'h0000_FFFF, "resv_mode_kept");
    rd_check(3'd4, 32'h0000_0000, "resv_blink_kept");
    rd_check(3'd6, 32'd1,         "resv_tick_div_kept");

    wr(3'd4, 32'd3);
    wr(3'd1, 32'h0000_0001);
    wr(3'd0, 32'h0000_00FF);
    step(8);
    expect_push("pre_rst_static", 32'h0000_00FE);
    expect_pop({24'd0, out_port & 8'hFE});
    #2;
    reset_n = 1'b0;
    #1;
    out_check(8'h00, "async_rst_out");
    rd_check(3'd0, 32'h0000_0000, "async_rst_data");
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    out_check(8'h00, "first_out_after_rst");
    rd_check(3'd1, 32'h0000_0000, "rst2_mode");
    rd_check(3'd4, 32'd250,       "rst2_blink");
    rd_check(3'd6, 32'd49999,     "rst2_tick_div");
    wr(3'd1, 32'h0000_0001);
    wr(3'd0, 32'h0000_0001);
    step(1);
    out_check(8'h01, "phase_one_after_rst");

    if (exp_q.size() != 0) check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
